// File: rtl/lsab_pkg.sv
// Shared widths, FIFO entry layout and helpers for the core-side LSAB sink.
package lsab_pkg;

    localparam int unsigned LSAB_DATA_W   = 32;
    localparam int unsigned LSAB_ANCILL_W = 25;
    localparam int unsigned LSAB_SLOTS    = 4;
    localparam int unsigned LSAB_LEN_W    = 16;
    localparam int unsigned LSAB_TURN_W   = $clog2(LSAB_SLOTS);

    // Entry layout, LSB first: data, ancillary word, last flag.
    localparam int unsigned LSAB_DATA_LSB   = 0;
    localparam int unsigned LSAB_ANCILL_LSB = LSAB_DATA_LSB + LSAB_DATA_W;
    localparam int unsigned LSAB_LAST_BIT   = LSAB_ANCILL_LSB + LSAB_ANCILL_W;
    localparam int unsigned LSAB_ENTRY_W    = LSAB_LAST_BIT + 1;

    typedef struct packed {
        logic                     last;
        logic [LSAB_ANCILL_W-1:0] ancill;
        logic [LSAB_DATA_W-1:0]   data;
    } lsab_entry_t;

    function automatic logic [LSAB_LEN_W-1:0] lsab_sat_inc(input logic [LSAB_LEN_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/lsab_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; head reads as zero while empty.
module lsab_sync_fifo #(
    parameter int unsigned WIDTH      = 58,
    parameter int unsigned DEPTH_LOG2 = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
    localparam int unsigned PTR_W = DEPTH_LOG2 + 1;
    localparam logic [PTR_W-1:0] PTR_ONE = 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic             do_push;
    logic             do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                     (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);

    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    assign dout_o = empty_o ? '0 : mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= din_i;
    end

endmodule

// File: rtl/lsab_cr_sink.sv
// Core-side receiver of one device->core LSAB channel: slot issue, buffering,
// DMA drain and block-complete interrupt with sticky error flags.
module lsab_cr_sink
    import lsab_pkg::*;
#(
    parameter int unsigned CHAN_ID    = 0,
    parameter int unsigned DEPTH_LOG2 = 3
) (
    input  logic                     CLK,
    input  logic                     RST,
    output logic [LSAB_TURN_W-1:0]   lsab_turn,
    input  logic [LSAB_DATA_W-1:0]   data_cr,
    input  logic [LSAB_ANCILL_W-1:0] ancill_cr,
    input  logic                     write_cr,
    input  logic                     int_cr,
    output logic [LSAB_DATA_W-1:0]   mem_data,
    output logic                     mem_last,
    output logic                     mem_valid,
    input  logic                     mem_ready,
    output logic                     irq,
    output logic [LSAB_LEN_W-1:0]    irq_len,
    output logic [LSAB_ANCILL_W-1:0] irq_ancill,
    input  logic                     irq_ack,
    output logic                     err_overflow,
    output logic                     err_slot,
    output logic                     err_irq_lost,
    input  logic                     err_clr
);

    localparam logic [LSAB_TURN_W-1:0] SLOT = LSAB_TURN_W'(CHAN_ID);

    logic [LSAB_TURN_W-1:0]   turn_q, turn_d;
    logic [LSAB_LEN_W-1:0]    cnt_q, cnt_d;
    logic                     irq_q, irq_d;
    logic [LSAB_LEN_W-1:0]    irq_len_q, irq_len_d;
    logic [LSAB_ANCILL_W-1:0] irq_anc_q, irq_anc_d;
    logic                     err_ovf_q, err_ovf_d;
    logic                     err_slot_q, err_slot_d;
    logic                     err_lost_q, err_lost_d;

    logic        in_slot;
    logic        full;
    logic        empty;
    logic        pop;
    logic        accept;
    logic        done;
    lsab_entry_t push_e;
    lsab_entry_t head_e;

    assign in_slot = (turn_q == SLOT);
    assign pop     = ~empty & mem_ready;
    assign accept  = write_cr & in_slot & (~full | pop);
    assign done    = pop & head_e.last;

    always_comb begin
        push_e.last   = int_cr;
        push_e.ancill = int_cr ? ancill_cr : '0;
        push_e.data   = data_cr;
    end

    lsab_sync_fifo #(
        .WIDTH      (LSAB_ENTRY_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk_i   (CLK),
        .rst_i   (RST),
        .push_i  (accept),
        .din_i   (push_e),
        .pop_i   (pop),
        .dout_o  (head_e),
        .full_o  (full),
        .empty_o (empty)
    );

    always_comb begin
        turn_d     = turn_q + 1'b1;
        cnt_d      = cnt_q;
        irq_d      = irq_q;
        irq_len_d  = irq_len_q;
        irq_anc_d  = irq_anc_q;
        err_ovf_d  = err_ovf_q;
        err_slot_d = err_slot_q;
        err_lost_d = err_lost_q;

        if (pop) cnt_d = lsab_sat_inc(cnt_q);

        // A completion in the ack cycle re-raises irq and does not count as lost.
        if (irq_ack) irq_d = 1'b0;
        if (done) begin
            cnt_d     = '0;
            irq_d     = 1'b1;
            irq_len_d = lsab_sat_inc(cnt_q);
            irq_anc_d = head_e.ancill;
            if (irq_q && !irq_ack) err_lost_d = 1'b1;
        end

        if (write_cr && !in_slot)        err_slot_d = 1'b1;
        if (write_cr && in_slot && !accept) err_ovf_d = 1'b1;

        if (err_clr) begin
            err_ovf_d  = 1'b0;
            err_slot_d = 1'b0;
            err_lost_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            turn_q     <= '0;
            cnt_q      <= '0;
            irq_q      <= 1'b0;
            irq_len_q  <= '0;
            irq_anc_q  <= '0;
            err_ovf_q  <= 1'b0;
            err_slot_q <= 1'b0;
            err_lost_q <= 1'b0;
        end else begin
            turn_q     <= turn_d;
            cnt_q      <= cnt_d;
            irq_q      <= irq_d;
            irq_len_q  <= irq_len_d;
            irq_anc_q  <= irq_anc_d;
            err_ovf_q  <= err_ovf_d;
            err_slot_q <= err_slot_d;
            err_lost_q <= err_lost_d;
        end
    end

    assign lsab_turn    = turn_q;
    assign mem_data     = head_e.data;
    assign mem_last     = head_e.last;
    assign mem_valid    = ~empty;
    assign irq          = irq_q;
    assign irq_len      = irq_len_q;
    assign irq_ancill   = irq_anc_q;
    assign err_overflow = err_ovf_q;
    assign err_slot     = err_slot_q;
    assign err_irq_lost = err_lost_q;

endmodule

// File: tb/tb_lsab_cr_sink.sv
// Directed bench for lsab_cr_sink (CHAN_ID=2, DEPTH_LOG2=3) with a word scoreboard.
module tb_lsab_cr_sink;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [1:0]  lsab_turn;
    logic [31:0] data_cr = '0;
    logic [24:0] ancill_cr = '0;
    logic        write_cr = 1'b0;
    logic        int_cr = 1'b0;
    logic [31:0] mem_data;
    logic        mem_last;
    logic        mem_valid;
    logic        mem_ready = 1'b0;
    logic        irq;
    logic [15:0] irq_len;
    logic [24:0] irq_ancill;
    logic        irq_ack = 1'b0;
    logic        err_overflow;
    logic        err_slot;
    logic        err_irq_lost;
    logic        err_clr = 1'b0;

    lsab_cr_sink #(.CHAN_ID(2), .DEPTH_LOG2(3)) dut (
        .CLK(CLK), .RST(RST), .lsab_turn(lsab_turn),
        .data_cr(data_cr), .ancill_cr(ancill_cr), .write_cr(write_cr), .int_cr(int_cr),
        .mem_data(mem_data), .mem_last(mem_last), .mem_valid(mem_valid), .mem_ready(mem_ready),
        .irq(irq), .irq_len(irq_len), .irq_ancill(irq_ancill), .irq_ack(irq_ack),
        .err_overflow(err_overflow), .err_slot(err_slot), .err_irq_lost(err_irq_lost),
        .err_clr(err_clr)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic        last;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total = 0;
    int   bad = 0;
    int   pops = 0;
    logic [1:0] tb_turn = '0;

    // Reference slot counter: free-running from reset.
    always @(posedge CLK) tb_turn <= RST ? 2'd0 : tb_turn + 2'd1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    always @(negedge CLK) begin
        if (!RST && mem_valid && mem_ready) begin
            chk("sb_has_entry", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                chk("mem_data", 64'(mem_data), 64'(mon_e.data));
                chk("mem_last", 64'(mem_last), 64'(mon_e.last));
            end
            pops++;
        end
    end

    task automatic do_reset();
        RST = 1'b1;
        write_cr = 1'b0; int_cr = 1'b0; irq_ack = 1'b0; err_clr = 1'b0; mem_ready = 1'b0;
        step();
        step();
        RST = 1'b0;
        sb.delete();
        pops = 0;
        chk("rst_turn", 64'(lsab_turn), 64'd0);
        chk("rst_valid", 64'(mem_valid), 64'd0);
        chk("rst_data", 64'({mem_last, mem_data}), 64'd0);
        chk("rst_irq", 64'({irq, irq_len, irq_ancill}), 64'd0);
        chk("rst_err", 64'({err_overflow, err_slot, err_irq_lost}), 64'd0);
    endtask

    task automatic wait_slot();
        for (int i = 0; i < 8 && tb_turn != 2'd2; i++) step();
        chk("slot_turn", 64'(lsab_turn), 64'd2);
    endtask

    // One write in the channel's slot; rdy_now asserts mem_ready for that cycle only.
    task automatic write_word(input logic [31:0] d, input logic last, input logic [24:0] anc,
                              input bit exp_acc, input bit rdy_now);
        wait_slot();
        write_cr = 1'b1; data_cr = d; int_cr = last; ancill_cr = anc;
        if (rdy_now) mem_ready = 1'b1;
        if (exp_acc) sb.push_back('{last: last, data: d});
        step();
        write_cr = 1'b0; int_cr = 1'b0;
        if (rdy_now) mem_ready = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 200 && sb.size() != 0; i++) step();
        chk("drain_done", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        // 1: write held 8 cycles, only slot-2 cycles accepted
        do_reset();
        mem_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            write_cr = 1'b1;
            data_cr = 32'h10 + 32'(k);
            if (tb_turn == 2'd2) sb.push_back('{last: 1'b0, data: 32'h10 + 32'(k)});
            step();
        end
        write_cr = 1'b0;
        chk("t1_err_slot", 64'(err_slot), 64'd1);
        wait_drain();
        step();
        chk("t1_pops", 64'(pops), 64'd2);
        chk("t1_valid_low", 64'(mem_valid), 64'd0);

        // 2: 5-word block -> irq with length and ancillary word
        do_reset();
        mem_ready = 1'b1;
        for (int k = 0; k < 4; k++) write_word(32'h20 + 32'(k), 1'b0, 25'h155, 1'b1, 1'b0);
        write_word(32'h24, 1'b1, 25'h1ABCDEF, 1'b1, 1'b0);
        wait_drain();
        chk("t2_irq", 64'(irq), 64'd1);
        chk("t2_len", 64'(irq_len), 64'd5);
        chk("t2_anc", 64'(irq_ancill), 64'h1ABCDEF);
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        chk("t2_irq_ack", 64'(irq), 64'd0);
        chk("t2_no_lost", 64'(err_irq_lost), 64'd0);

        // 3: fill with mem_ready low, 9th write overflows
        do_reset();
        for (int k = 0; k < 9; k++) write_word(32'h30 + 32'(k), 1'b0, '0, k < 8, 1'b0);
        chk("t3_overflow", 64'(err_overflow), 64'd1);
        chk("t3_slot_ok", 64'(err_slot), 64'd0);
        chk("t3_head", 64'({mem_valid, mem_data}), 64'h1_0000_0030);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("t3_clr", 64'(err_overflow), 64'd0);

        // 4: full with simultaneous pop -> accepted, then still full
        write_word(32'h40, 1'b0, '0, 1'b1, 1'b1);
        chk("t4_no_overflow", 64'(err_overflow), 64'd0);
        chk("t4_pops", 64'(pops), 64'd1);
        write_word(32'h41, 1'b0, '0, 1'b0, 1'b0);
        chk("t4_still_full", 64'(err_overflow), 64'd1);
        mem_ready = 1'b1;
        wait_drain();
        step();
        chk("t34_pops", 64'(pops), 64'd9);
        chk("t34_empty", 64'(mem_valid), 64'd0);

        // 5: two 1-word blocks without ack -> lost irq flagged
        do_reset();
        mem_ready = 1'b1;
        write_word(32'h50, 1'b1, 25'h0000111, 1'b1, 1'b0);
        write_word(32'h51, 1'b1, 25'h1555555, 1'b1, 1'b0);
        wait_drain();
        chk("t5_irq", 64'(irq), 64'd1);
        chk("t5_len", 64'(irq_len), 64'd1);
        chk("t5_anc", 64'(irq_ancill), 64'h1555555);
        chk("t5_lost", 64'(err_irq_lost), 64'd1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("t5_lost_clr", 64'(err_irq_lost), 64'd0);

        // 6: reset mid-block flushes FIFO and count
        do_reset();
        for (int k = 0; k < 3; k++) write_word(32'h60 + 32'(k), 1'b0, '0, 1'b1, 1'b0);
        chk("t6_pre_valid", 64'(mem_valid), 64'd1);
        do_reset();
        chk("t6_irq", 64'(irq), 64'd0);
        mem_ready = 1'b1;
        write_word(32'h70, 1'b0, '0, 1'b1, 1'b0);
        write_word(32'h71, 1'b1, 25'h0ABCDE, 1'b1, 1'b0);
        wait_drain();
        chk("t6_irq_new", 64'(irq), 64'd1);
        chk("t6_len", 64'(irq_len), 64'd2);
        chk("t6_anc", 64'(irq_ancill), 64'h0ABCDE);
        chk("t6_pops", 64'(pops), 64'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
